// File: rtl/prbs_pkg.sv
// Shared types and reference constants for the PRBS5 (x^5 style, period-7 serial) checker.
package prbs_pkg;

    typedef enum logic [1:0] {
        FILL,
        HUNT,
        LOCK
    } state_t;

    localparam int unsigned HIST_W      = 3;
    localparam int unsigned PERIOD      = 7;
    localparam logic [4:0]  SEED        = 5'b00010;
    // Bit i is the i-th generator output bit: 0,0,1,1,1,0,1
    localparam logic [PERIOD-1:0] REF_PATTERN = 7'b1011100;

    // Serial recurrence s[n+1] = s[n] ^ s[n-2], with h[0] the newest bit
    function automatic logic predict(input logic [HIST_W-1:0] h);
        return h[0] ^ h[2];
    endfunction

endpackage

// File: rtl/prbs5_predictor.sv
// Three-bit stream history and the predicted next bit; the shift source is either
// the received bit (acquisition) or the prediction itself (flywheel while locked).
module prbs5_predictor
    import prbs_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              shift,
    input  logic              use_expected,
    input  logic              bit_in,
    output logic [HIST_W-1:0] hist,
    output logic              expected_c
);

    assign expected_c = predict(hist);

    always_ff @(posedge clk) begin
        if (reset) begin
            hist <= '0;
        end else if (shift) begin
            hist <= {hist[HIST_W-2:0], (use_expected ? expected_c : bit_in)};
        end
    end

endmodule

// File: rtl/prbs5_checker.sv
// PRBS5 serial stream checker: fill/hunt/lock acquisition with flywheel tracking,
// error strobe and saturating error counter. Define PRBS_CHK_STATS_EN for bit_count.
module prbs5_checker
    import prbs_pkg::*;
#(
    parameter int unsigned LOCK_THRESH = 7,
    parameter int unsigned LOSS_THRESH = 3,
    parameter int unsigned ERR_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic             err_clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [31:0]      bit_count
);

    localparam int unsigned RUN_W  = $clog2(LOCK_THRESH + 1);
    localparam int unsigned MISS_W = $clog2(LOSS_THRESH + 1);

    state_t            state;
    logic [1:0]        fill_cnt;
    logic [RUN_W-1:0]  run_cnt;
    logic [MISS_W-1:0] miss_cnt;
    logic [HIST_W-1:0] hist;
    logic              expected_c;
    logic              match_c;
    logic              run_hit_c;
    logic              miss_hit_c;
    logic              count_err_c;

    prbs5_predictor u_predictor (
        .clk          (clk),
        .reset        (reset),
        .shift        (bit_valid),
        .use_expected (state == LOCK),
        .bit_in       (bit_in),
        .hist         (hist),
        .expected_c   (expected_c)
    );

    assign match_c     = (bit_in == expected_c);
    assign run_hit_c   = ((32'(run_cnt) + 32'd1) == LOCK_THRESH);
    assign miss_hit_c  = ((32'(miss_cnt) + 32'd1) == LOSS_THRESH);
    assign count_err_c = bit_valid && (state == LOCK) && !match_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FILL;
            fill_cnt  <= '0;
            run_cnt   <= '0;
            miss_cnt  <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            err_pulse <= 1'b0;
            if (bit_valid) begin
                unique case (state)
                    FILL: begin
                        if (fill_cnt == 2'd2) begin
                            state    <= HUNT;
                            fill_cnt <= '0;
                            run_cnt  <= '0;
                        end else begin
                            fill_cnt <= fill_cnt + 2'd1;
                        end
                    end
                    HUNT: begin
                        // An all-zero history predicts 0 forever, so it never counts toward lock
                        if (match_c && (hist != '0)) begin
                            if (run_hit_c) begin
                                state    <= LOCK;
                                locked   <= 1'b1;
                                run_cnt  <= '0;
                                miss_cnt <= '0;
                            end else begin
                                run_cnt <= run_cnt + RUN_W'(1);
                            end
                        end else begin
                            run_cnt <= '0;
                        end
                    end
                    LOCK: begin
                        if (!match_c) begin
                            err_pulse <= 1'b1;
                            if (miss_hit_c) begin
                                state    <= FILL;
                                locked   <= 1'b0;
                                fill_cnt <= '0;
                                miss_cnt <= '0;
                            end else begin
                                miss_cnt <= miss_cnt + MISS_W'(1);
                            end
                        end else begin
                            miss_cnt <= '0;
                        end
                    end
                    default: state <= FILL;
                endcase
            end

            if (err_clr) begin
                err_count <= '0;
            end else if (count_err_c && (err_count != '1)) begin
                err_count <= err_count + ERR_W'(1);
            end
        end
    end

`ifdef PRBS_CHK_STATS_EN
    // Counts every bit checked while locked; wraps freely
    always_ff @(posedge clk) begin
        if (reset || err_clr) begin
            bit_count <= '0;
        end else if (bit_valid && (state == LOCK)) begin
            bit_count <= bit_count + 32'd1;
        end
    end
`else
    assign bit_count = '0;
`endif

endmodule

// File: tb/tb_prbs5_checker.sv
// Self-checking bench for prbs5_checker: a default instance and an ERR_W=4 instance
// share stimulus; a behavioural model pushes expected outputs to a scoreboard queue.
module tb_prbs5_checker;
    import prbs_pkg::*;

    localparam int LOCK_T = 7;
    localparam int LOSS_T = 3;

    typedef struct packed {
        logic        locked;
        logic        pulse;
        logic [15:0] err;
        logic        locked4;
        logic        pulse4;
        logic [3:0]  err4;
        logic [31:0] bits;
        logic [31:0] bits4;
    } obs_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        bit_valid = 1'b0;
    logic        bit_in = 1'b0;
    logic        err_clr = 1'b0;
    logic        locked, err_pulse, locked4, err_pulse4;
    logic [15:0] err_count;
    logic [3:0]  err_count4;
    logic [31:0] bit_count, bit_count4;

    int   checks = 0;
    int   fails = 0;
    obs_t sb[$];
    obs_t exp_o;
    obs_t m_out = '0;
    int   m_state = 0, m_fill = 0, m_run = 0, m_miss = 0;
    logic [2:0] m_hist = '0;
    logic [4:0] lfsr = SEED;

    always #5 clk = ~clk;

    prbs5_checker dut (
        .clk(clk), .reset(reset), .bit_valid(bit_valid), .bit_in(bit_in), .err_clr(err_clr),
        .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .bit_count(bit_count)
    );

    prbs5_checker #(.ERR_W(4)) dut4 (
        .clk(clk), .reset(reset), .bit_valid(bit_valid), .bit_in(bit_in), .err_clr(err_clr),
        .locked(locked4), .err_pulse(err_pulse4), .err_count(err_count4), .bit_count(bit_count4)
    );

    function automatic obs_t sample();
        return {locked, err_pulse, err_count, locked4, err_pulse4, err_count4, bit_count, bit_count4};
    endfunction

    // Generator: shift left, q0 <= q2 ^ q0, output q0
    task automatic next_bit(output logic b);
        b = lfsr[0];
        lfsr = {lfsr[3:0], lfsr[2] ^ lfsr[0]};
    endtask

    // Drive one cycle, predict the outputs after the edge, and queue the prediction
    task automatic step(input logic v, input logic b, input logic clr, input logic rst);
        logic e;
        logic bad;
        obs_t x;
        bit_valid = v; bit_in = b; err_clr = clr; reset = rst;
        x = m_out; x.pulse = 1'b0; bad = 1'b0;
        if (rst) begin
            m_state = 0; m_fill = 0; m_run = 0; m_miss = 0; m_hist = '0; x = '0;
        end else begin
            if (v) begin
                e = m_hist[0] ^ m_hist[2];
                case (m_state)
                    0: begin
                        m_hist = {m_hist[1:0], b};
                        m_fill++;
                        if (m_fill == 3) begin m_state = 1; m_run = 0; m_fill = 0; end
                    end
                    1: begin
                        if (b == e && m_hist != 3'b000) m_run++; else m_run = 0;
                        m_hist = {m_hist[1:0], b};
                        if (m_run == LOCK_T) begin m_state = 2; m_miss = 0; m_run = 0; x.locked = 1'b1; end
                    end
                    default: begin
                        m_hist = {m_hist[1:0], e};
`ifdef PRBS_CHK_STATS_EN
                        x.bits = x.bits + 32'd1;
`endif
                        if (b != e) begin
                            bad = 1'b1; x.pulse = 1'b1; m_miss++;
                            if (m_miss == LOSS_T) begin m_state = 0; m_fill = 0; m_miss = 0; x.locked = 1'b0; end
                        end else begin
                            m_miss = 0;
                        end
                    end
                endcase
            end
            if (clr) begin
                x.err = '0; x.err4 = '0; x.bits = '0;
            end else if (bad) begin
                if (x.err != 16'hFFFF) x.err = x.err + 16'd1;
                if (x.err4 != 4'hF) x.err4 = x.err4 + 4'd1;
            end
        end
        x.locked4 = x.locked; x.pulse4 = x.pulse; x.bits4 = x.bits;
        m_out = x;
        sb.push_back(x);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, 1'b1, 1'b1);
        exp_o = sb.pop_front(); checks++;
        if (sample() !== exp_o) begin fails++; $display("FAIL reset_sb: got %h want %h", sample(), exp_o); end
        checks++;
        if ({locked, err_pulse, err_count, bit_count} !== 50'd0) begin
            fails++; $display("FAIL reset_outputs: got %h want 0", {locked, err_pulse, err_count, bit_count});
        end
    endtask

    task automatic test_lock();
        logic b;
        lfsr = SEED;
        for (int i = 1; i <= 15; i++) begin
            next_bit(b);
            step(1'b1, b, 1'b0, 1'b0);
            exp_o = sb.pop_front(); checks++;
            if (sample() !== exp_o) begin fails++; $display("FAIL lock_seq bit %0d: got %h want %h", i, sample(), exp_o); end
            if (i == 9) begin
                checks++;
                if (locked !== 1'b0) begin fails++; $display("FAIL lock_early: got %b want 0", locked); end
            end
            if (i == 10) begin
                checks++;
                if (locked !== 1'b1) begin fails++; $display("FAIL lock_point: got %b want 1", locked); end
            end
        end
        checks++;
        if (err_count !== 16'd0) begin fails++; $display("FAIL lock_err: got %0d want 0", err_count); end
    endtask

    task automatic test_single_error();
        logic b;
        next_bit(b);
        step(1'b1, ~b, 1'b0, 1'b0);
        exp_o = sb.pop_front(); checks++;
        if (sample() !== exp_o) begin fails++; $display("FAIL single_bad: got %h want %h", sample(), exp_o); end
        checks++;
        if ({err_pulse, locked, err_count} !== {1'b1, 1'b1, 16'd1}) begin
            fails++; $display("FAIL single_pulse: got %b %b %0d want 1 1 1", err_pulse, locked, err_count);
        end
        for (int i = 0; i < 10; i++) begin
            next_bit(b);
            step(1'b1, b, 1'b0, 1'b0);
            exp_o = sb.pop_front(); checks++;
            if (sample() !== exp_o) begin fails++; $display("FAIL single_after %0d: got %h want %h", i, sample(), exp_o); end
            checks++;
            if (err_pulse !== 1'b0 || err_count !== 16'd1 || locked !== 1'b1) begin
                fails++; $display("FAIL single_hold %0d: got %b %0d %b want 0 1 1", i, err_pulse, err_count, locked);
            end
        end
    endtask

    task automatic test_burst_loss();
        logic b;
        step(1'b0, 1'b0, 1'b1, 1'b0);
        exp_o = sb.pop_front(); checks++;
        if (sample() !== exp_o) begin fails++; $display("FAIL burst_clr: got %h want %h", sample(), exp_o); end
        for (int k = 1; k <= 3; k++) begin
            next_bit(b);
            step(1'b1, ~b, 1'b0, 1'b0);
            exp_o = sb.pop_front(); checks++;
            if (sample() !== exp_o) begin fails++; $display("FAIL burst_bad %0d: got %h want %h", k, sample(), exp_o); end
            checks++;
            if (locked !== (k < 3) || err_count !== 16'(k)) begin
                fails++; $display("FAIL burst_state %0d: got %b %0d want %b %0d", k, locked, err_count, (k < 3), k);
            end
        end
        for (int i = 1; i <= 12; i++) begin
            next_bit(b);
            step(1'b1, b, 1'b0, 1'b0);
            exp_o = sb.pop_front(); checks++;
            if (sample() !== exp_o) begin fails++; $display("FAIL relock %0d: got %h want %h", i, sample(), exp_o); end
            if (i == 9 || i == 10) begin
                checks++;
                if (locked !== (i == 10)) begin fails++; $display("FAIL relock_point %0d: got %b want %b", i, locked, (i == 10)); end
            end
        end
        checks++;
        if (err_count !== 16'd3) begin fails++; $display("FAIL relock_err: got %0d want 3", err_count); end
    endtask

    task automatic test_saturate();
        logic b;
        for (int i = 0; i < 40; i++) begin
            next_bit(b);
            step(1'b1, (i % 2 == 0) ? ~b : b, 1'b0, 1'b0);
            exp_o = sb.pop_front(); checks++;
            if (sample() !== exp_o) begin fails++; $display("FAIL sat_seq %0d: got %h want %h", i, sample(), exp_o); end
        end
        checks++;
        if ({locked4, err_count4, err_count} !== {1'b1, 4'd15, 16'd23}) begin
            fails++; $display("FAIL sat_value: got %b %0d %0d want 1 15 23", locked4, err_count4, err_count);
        end
        next_bit(b);
        step(1'b1, ~b, 1'b1, 1'b0);
        exp_o = sb.pop_front(); checks++;
        if (sample() !== exp_o) begin fails++; $display("FAIL clr_vs_err: got %h want %h", sample(), exp_o); end
        checks++;
        if ({err_pulse, err_count, err_count4} !== {1'b1, 16'd0, 4'd0}) begin
            fails++; $display("FAIL clr_wins: got %b %0d %0d want 1 0 0", err_pulse, err_count, err_count4);
        end
    endtask

    task automatic test_reset_mid_lock();
        logic b;
        next_bit(b);
        step(1'b1, ~b, 1'b1, 1'b1);
        exp_o = sb.pop_front(); checks++;
        if (sample() !== exp_o) begin fails++; $display("FAIL rst_lock_sb: got %h want %h", sample(), exp_o); end
        checks++;
        if (sample() !== '0) begin fails++; $display("FAIL rst_lock_zero: got %h want 0", sample()); end
    endtask

    task automatic test_zero_stream();
        for (int i = 0; i < 50; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            exp_o = sb.pop_front(); checks++;
            if (sample() !== exp_o) begin fails++; $display("FAIL zero_seq %0d: got %h want %h", i, sample(), exp_o); end
            checks++;
            if (locked !== 1'b0) begin fails++; $display("FAIL zero_lock %0d: got %b want 0", i, locked); end
        end
    endtask

    task automatic test_gapped();
        logic b;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        exp_o = sb.pop_front(); checks++;
        if (sample() !== exp_o) begin fails++; $display("FAIL gap_rst: got %h want %h", sample(), exp_o); end
        for (int i = 1; i <= 12; i++) begin
            b = REF_PATTERN[(i - 1) % PERIOD];
            step(1'b1, b, 1'b0, 1'b0);
            exp_o = sb.pop_front(); checks++;
            if (sample() !== exp_o) begin fails++; $display("FAIL gap_valid %0d: got %h want %h", i, sample(), exp_o); end
            if (i == 9 || i == 10) begin
                checks++;
                if (locked !== (i == 10)) begin fails++; $display("FAIL gap_lock %0d: got %b want %b", i, locked, (i == 10)); end
            end
            for (int g = 0; g < 2; g++) begin
                step(1'b0, ~b, 1'b0, 1'b0);
                exp_o = sb.pop_front(); checks++;
                if (sample() !== exp_o) begin fails++; $display("FAIL gap_idle %0d.%0d: got %h want %h", i, g, sample(), exp_o); end
                checks++;
                if (err_pulse !== 1'b0) begin fails++; $display("FAIL gap_pulse %0d: got %b want 0", i, err_pulse); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_single_error();
        test_burst_loss();
        test_saturate();
        test_reset_mid_lock();
        test_zero_stream();
        test_gapped();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
